// File: rtl/fp16_align_add.sv
// FP16 add/subtract front end: unpacks two binary16 operands, aligns the smaller
// mantissa one bit per cycle, and adds/subtracts into the normalizer's input form.
module fp16_align_add (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_A,
  input  logic [15:0] IN_B,
  input  logic        IN_SUB,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_SIGN,
  output logic [4:0]  OUT_EXP,
  output logic [11:0] OUT_MANT,
  output logic [1:0]  OUT_EXC,
  output logic [1:0]  DBG_STATE
);

  // Handshake: an operand pair transfers on a rising edge where IN_VALID and
  // IN_READY are both high; a result transfers on a rising edge where OUT_VALID
  // and OUT_READY are both high. Neither valid depends combinationally on ready.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] EXC_FINITE = 2'b00;
  localparam logic [1:0] EXC_INF    = 2'b01;
  localparam logic [1:0] EXC_NAN    = 2'b10;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [10:0] big_mant_q;
  logic [10:0] small_mant_q;
  logic [4:0]  big_exp_q;
  logic        big_sign_q;
  logic        eff_sub_q;
  logic        zero_sign_q;
  logic [1:0]  exc_q;
  logic        exc_sign_q;

  // Operand unpacking
  logic        sign_a;
  logic        sign_b_eff;
  logic [4:0]  exp_a;
  logic [4:0]  exp_b;
  logic [9:0]  frac_a;
  logic [9:0]  frac_b;
  logic [4:0]  eexp_a;
  logic [4:0]  eexp_b;
  logic [10:0] mant_a;
  logic [10:0] mant_b;

  assign sign_a     = IN_A[15];
  assign sign_b_eff = IN_B[15] ^ IN_SUB;
  assign exp_a      = IN_A[14:10];
  assign exp_b      = IN_B[14:10];
  assign frac_a     = IN_A[9:0];
  assign frac_b     = IN_B[9:0];
  assign eexp_a     = (exp_a == 5'd0) ? 5'd1 : exp_a;
  assign eexp_b     = (exp_b == 5'd0) ? 5'd1 : exp_b;
  assign mant_a     = {(exp_a != 5'd0), frac_a};
  assign mant_b     = {(exp_b != 5'd0), frac_b};

  // Swap so "big" holds the larger {exp, frac}; a tie keeps A as big.
  logic        a_big;
  logic [10:0] big_mant_in;
  logic [10:0] small_mant_in;
  logic [4:0]  big_eexp_in;
  logic [4:0]  small_eexp_in;
  logic        big_sign_in;
  logic [4:0]  exp_diff;
  logic [3:0]  shift_cnt;

  assign a_big         = (IN_A[14:0] >= IN_B[14:0]);
  assign big_mant_in   = a_big ? mant_a : mant_b;
  assign small_mant_in = a_big ? mant_b : mant_a;
  assign big_eexp_in   = a_big ? eexp_a : eexp_b;
  assign small_eexp_in = a_big ? eexp_b : eexp_a;
  assign big_sign_in   = a_big ? sign_a : sign_b_eff;
  assign exp_diff      = big_eexp_in - small_eexp_in;
  assign shift_cnt     = (exp_diff > 5'd11) ? 4'd11 : exp_diff[3:0];

  // Special-value classification
  logic eff_sub_in;
  logic nan_a;
  logic nan_b;
  logic inf_a;
  logic inf_b;
  logic [1:0] exc_in;
  logic       exc_sign_in;

  assign eff_sub_in = sign_a ^ sign_b_eff;
  assign nan_a      = (exp_a == 5'd31) && (frac_a != 10'd0);
  assign nan_b      = (exp_b == 5'd31) && (frac_b != 10'd0);
  assign inf_a      = (exp_a == 5'd31) && (frac_a == 10'd0);
  assign inf_b      = (exp_b == 5'd31) && (frac_b == 10'd0);

  always_comb begin
    exc_in      = EXC_FINITE;
    exc_sign_in = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub_in)) begin
      exc_in      = EXC_NAN;
      exc_sign_in = 1'b0;
    end else if (inf_a) begin
      exc_in      = EXC_INF;
      exc_sign_in = sign_a;
    end else if (inf_b) begin
      exc_in      = EXC_INF;
      exc_sign_in = sign_b_eff;
    end
  end

  // Result arithmetic on the aligned registers; the swap keeps it non-negative.
  logic [11:0] sum;

  always_comb begin
    if (eff_sub_q) begin
      sum = {1'b0, big_mant_q} - {1'b0, small_mant_q};
    end else begin
      sum = {1'b0, big_mant_q} + {1'b0, small_mant_q};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      big_mant_q   <= 11'd0;
      small_mant_q <= 11'd0;
      big_exp_q    <= 5'd0;
      big_sign_q   <= 1'b0;
      eff_sub_q    <= 1'b0;
      zero_sign_q  <= 1'b0;
      exc_q        <= EXC_FINITE;
      exc_sign_q   <= 1'b0;
      OUT_SIGN     <= 1'b0;
      OUT_EXP      <= 5'd0;
      OUT_MANT     <= 12'd0;
      OUT_EXC      <= EXC_FINITE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            big_mant_q   <= big_mant_in;
            small_mant_q <= small_mant_in;
            big_exp_q    <= big_eexp_in;
            big_sign_q   <= big_sign_in;
            eff_sub_q    <= eff_sub_in;
            zero_sign_q  <= sign_a & sign_b_eff;
            exc_q        <= exc_in;
            exc_sign_q   <= exc_sign_in;
            cnt          <= (exc_in != EXC_FINITE) ? 4'd0 : shift_cnt;
            state        <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (cnt != 4'd0) begin
            // Truncating shift: bits falling off the bottom are discarded.
            small_mant_q <= {1'b0, small_mant_q[10:1]};
            cnt          <= cnt - 4'd1;
          end else begin
            if (exc_q != EXC_FINITE) begin
              OUT_SIGN <= exc_sign_q;
              OUT_EXP  <= 5'd31;
              OUT_MANT <= 12'd0;
              OUT_EXC  <= exc_q;
            end else if (sum == 12'd0) begin
              OUT_SIGN <= zero_sign_q;
              OUT_EXP  <= 5'd0;
              OUT_MANT <= 12'd0;
              OUT_EXC  <= EXC_FINITE;
            end else begin
              OUT_SIGN <= big_sign_q;
              OUT_EXP  <= big_exp_q;
              OUT_MANT <= sum;
              OUT_EXC  <= EXC_FINITE;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = (state == ST_IDLE);
  assign OUT_VALID = (state == ST_DONE);
  assign DBG_STATE = state;

endmodule
